// File: rtl/wts_wave_stream_writer.sv
// Double-buffered host-to-wave-RAM streamer: fills the half not being played.
// Optional build macro WTS_STREAM_SIGNED_EN converts two's complement samples to offset binary.
module wts_wave_stream_writer (
  input  logic       clk,
  input  logic       nreset,
  input  logic       stream_enable,
  input  logic [1:0] reg_wave_length,
  input  logic       half_timing,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       ram_we,
  output logic [6:0] ram_address,
  output logic [7:0] ram_wdata,
  output logic       half_request,
  output logic       fill_half,
  output logic       underrun
);

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned LEN_W  = 2;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_WAIT} state_t;

  state_t              r_state;
  logic                r_play_half;
  logic                r_fill_half;
  logic                r_underrun;
  logic                r_en_d;
  logic                r_we;
  logic [IDX_W-1:0]    r_index;
  logic [LEN_W-1:0]    r_len;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_accept;
  logic                w_last;
  logic [IDX_W-1:0]    w_last_idx;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;

  assign s_ready      = stream_enable && (r_state == ST_FILL);
  assign w_accept     = s_valid && s_ready;
  assign half_request = (r_state == ST_FILL);
  assign fill_half    = r_fill_half;
  assign underrun     = r_underrun;
  assign ram_we       = r_we;
  assign ram_address  = r_addr;
  assign ram_wdata    = r_wdata;

  // Half size and half-select bit position follow the latched length code.
  always_comb begin
    w_last_idx = IDX_W'(63);
    w_addr     = {r_fill_half, r_index};
    case (r_len)
      2'b00: begin
        w_last_idx = IDX_W'(15);
        w_addr     = {2'b00, r_fill_half, r_index[3:0]};
      end
      2'b01: begin
        w_last_idx = IDX_W'(31);
        w_addr     = {1'b0, r_fill_half, r_index[4:0]};
      end
      default: begin
        w_last_idx = IDX_W'(63);
        w_addr     = {r_fill_half, r_index};
      end
    endcase
  end

  assign w_last = (r_index == w_last_idx);

`ifdef WTS_STREAM_SIGNED_EN
  assign w_wdata = {~s_data[7], s_data[6:0]};
`else
  assign w_wdata = s_data;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= ST_IDLE;
      r_play_half <= 1'b0;
      r_fill_half <= 1'b0;
      r_underrun  <= 1'b0;
      r_en_d      <= 1'b0;
      r_we        <= 1'b0;
      r_index     <= '0;
      r_len       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_en_d <= stream_enable;
      r_we   <= w_accept;
      if (w_accept) begin
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
      end
      if (!stream_enable) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!r_en_d) begin
              r_len       <= reg_wave_length;
              r_play_half <= 1'b0;
              r_fill_half <= 1'b1;
              r_index     <= '0;
              r_underrun  <= 1'b0;
              r_state     <= ST_FILL;
            end
          end
          ST_FILL: begin
            if (half_timing) begin
              // A completing last beat in the same cycle is not an underrun.
              if (!(w_accept && w_last)) r_underrun <= 1'b1;
              r_play_half <= ~r_play_half;
              r_fill_half <= r_play_half;
              r_index     <= '0;
            end else if (w_accept) begin
              if (w_last) begin
                r_index <= '0;
                r_state <= ST_WAIT;
              end else begin
                r_index <= r_index + IDX_W'(1);
              end
            end
          end
          ST_WAIT: begin
            if (half_timing) begin
              r_play_half <= ~r_play_half;
              r_fill_half <= r_play_half;
              r_index     <= '0;
              r_state     <= ST_FILL;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wts_wave_stream_writer.sv
// Directed self-checking bench for wts_wave_stream_writer.
module tb_wts_wave_stream_writer;

  logic       clk = 1'b0;
  logic       nreset = 1'b1;
  logic       stream_enable = 1'b0;
  logic [1:0] reg_wave_length = 2'b00;
  logic       half_timing = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready;
  logic       ram_we;
  logic [6:0] ram_address;
  logic [7:0] ram_wdata;
  logic       half_request;
  logic       fill_half;
  logic       underrun;

  int checks = 0;
  int failures = 0;

  wts_wave_stream_writer dut (
    .clk             (clk),
    .nreset          (nreset),
    .stream_enable   (stream_enable),
    .reg_wave_length (reg_wave_length),
    .half_timing     (half_timing),
    .s_valid         (s_valid),
    .s_data          (s_data),
    .s_ready         (s_ready),
    .ram_we          (ram_we),
    .ram_address     (ram_address),
    .ram_wdata       (ram_wdata),
    .half_request    (half_request),
    .fill_half       (fill_half),
    .underrun        (underrun)
  );

  always #5 clk = ~clk;

`ifdef WTS_STREAM_SIGNED_EN
  localparam logic [7:0] EXP_80 = 8'h00;
  localparam logic [7:0] EXP_7F = 8'hFF;
  function automatic logic [7:0] exp_wdata(input logic [7:0] d);
    return {~d[7], d[6:0]};
  endfunction
`else
  localparam logic [7:0] EXP_80 = 8'h80;
  localparam logic [7:0] EXP_7F = 8'h7F;
  function automatic logic [7:0] exp_wdata(input logic [7:0] d);
    return d;
  endfunction
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat (optionally with half_timing) and check the write that follows.
  task automatic send_beat(input logic [7:0] d, input logic [6:0] addr, input logic ht);
    s_valid = 1'b1;
    s_data = d;
    half_timing = ht;
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL beat_ready data=%h: got s_ready=%b expected 1", d, s_ready);
    end
    step();
    half_timing = 1'b0;
    checks++;
    if (ram_we !== 1'b1 || ram_address !== addr || ram_wdata !== exp_wdata(d)) begin
      failures++;
      $display("FAIL beat_write data=%h: got we=%b addr=%h wdata=%h expected we=1 addr=%h wdata=%h",
               d, ram_we, ram_address, ram_wdata, addr, exp_wdata(d));
    end
  endtask

  task automatic stop_valid();
    s_valid = 1'b0;
    step();
    checks++;
    if (ram_we !== 1'b0) begin
      failures++;
      $display("FAIL we_single_cycle: got ram_we=%b expected 0", ram_we);
    end
  endtask

  task automatic start_stream(input logic [1:0] len);
    stream_enable = 1'b0;
    step();
    reg_wave_length = len;
    stream_enable = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      $display("FAIL start_ready_early: got s_ready=%b expected 0", s_ready);
    end
    step();
    checks++;
    if (s_ready !== 1'b1 || half_request !== 1'b1 || fill_half !== 1'b1 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL start_state: got ready=%b hreq=%b fill=%b underrun=%b expected 1 1 1 0",
               s_ready, half_request, fill_half, underrun);
    end
  endtask

  task automatic test_reset();
    #1 nreset = 1'b0;
    step();
    step();
    checks++;
    if ({s_ready, ram_we, ram_address, ram_wdata, half_request, fill_half, underrun} !== 20'h0) begin
      failures++;
      $display("FAIL reset_outputs: got ready=%b we=%b addr=%h wdata=%h hreq=%b fill=%b ur=%b expected all 0",
               s_ready, ram_we, ram_address, ram_wdata, half_request, fill_half, underrun);
    end
    nreset = 1'b1;
    step();
    // Reset lands while a beat is being accepted: its write must be dropped.
    start_stream(2'b00);
    s_valid = 1'b1;
    s_data = 8'h55;
    #2 nreset = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b0 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_write_async: got ready=%b we=%b expected 0 0", s_ready, ram_we);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({s_ready, ram_we, ram_address, ram_wdata, half_request, fill_half, underrun} !== 20'h0) begin
        failures++;
        $display("FAIL reset_mid_write cycle=%0d: got we=%b addr=%h wdata=%h hreq=%b fill=%b expected all 0",
                 i, ram_we, ram_address, ram_wdata, half_request, fill_half);
      end
    end
    s_valid = 1'b0;
    stream_enable = 1'b0;
    nreset = 1'b1;
    step();
  endtask

  task automatic test_len00_prime();
    start_stream(2'b00);
    for (int i = 0; i < 16; i++) send_beat(8'(i), 7'(8'h10 + i), 1'b0);
    checks++;
    if (s_ready !== 1'b0 || half_request !== 1'b0) begin
      failures++;
      $display("FAIL prime_wait: got ready=%b hreq=%b expected 0 0", s_ready, half_request);
    end
    stop_valid();
  endtask

  task automatic test_half_swap();
    half_timing = 1'b1;
    step();
    half_timing = 1'b0;
    checks++;
    if (fill_half !== 1'b0 || half_request !== 1'b1 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL swap_state: got fill=%b hreq=%b ur=%b expected 0 1 0", fill_half, half_request, underrun);
    end
    for (int i = 0; i < 16; i++) send_beat(8'(8'h20 + i), 7'(i), 1'b0);
    stop_valid();
    checks++;
    if (underrun !== 1'b0 || half_request !== 1'b0) begin
      failures++;
      $display("FAIL swap_done: got ur=%b hreq=%b expected 0 0", underrun, half_request);
    end
  endtask

  task automatic test_underrun();
    start_stream(2'b01);
    for (int i = 0; i < 10; i++) send_beat(8'(8'h30 + i), 7'(8'h20 + i), 1'b0);
    stop_valid();
    half_timing = 1'b1;
    step();
    half_timing = 1'b0;
    checks++;
    if (underrun !== 1'b1 || fill_half !== 1'b0 || half_request !== 1'b1) begin
      failures++;
      $display("FAIL underrun_set: got ur=%b fill=%b hreq=%b expected 1 0 1", underrun, fill_half, half_request);
    end
    send_beat(8'hAA, 7'h00, 1'b0);
    stop_valid();
    stream_enable = 1'b0;
    step();
    checks++;
    if (underrun !== 1'b1 || half_request !== 1'b0) begin
      failures++;
      $display("FAIL underrun_sticky: got ur=%b hreq=%b expected 1 0", underrun, half_request);
    end
  endtask

  task automatic test_simultaneous();
    start_stream(2'b00);
    for (int i = 0; i < 15; i++) send_beat(8'(8'h40 + i), 7'(8'h10 + i), 1'b0);
    send_beat(8'h4F, 7'h1F, 1'b1);
    checks++;
    if (underrun !== 1'b0 || fill_half !== 1'b0 || half_request !== 1'b1) begin
      failures++;
      $display("FAIL sim_last: got ur=%b fill=%b hreq=%b expected 0 0 1", underrun, fill_half, half_request);
    end
    send_beat(8'h50, 7'h00, 1'b0);
    send_beat(8'h51, 7'h01, 1'b1);
    checks++;
    if (underrun !== 1'b1 || fill_half !== 1'b1) begin
      failures++;
      $display("FAIL sim_nonlast: got ur=%b fill=%b expected 1 1", underrun, fill_half);
    end
  endtask

  task automatic test_sign();
    send_beat(8'h80, 7'h10, 1'b0);
    checks++;
    if (ram_wdata !== EXP_80) begin
      failures++;
      $display("FAIL sign_80: got wdata=%h expected %h", ram_wdata, EXP_80);
    end
    send_beat(8'h7F, 7'h11, 1'b0);
    checks++;
    if (ram_wdata !== EXP_7F) begin
      failures++;
      $display("FAIL sign_7f: got wdata=%h expected %h", ram_wdata, EXP_7F);
    end
    stop_valid();
  endtask

  task automatic test_len128_disable();
    start_stream(2'b10);
    send_beat(8'h11, 7'h40, 1'b0);
    reg_wave_length = 2'b00;
    send_beat(8'h22, 7'h41, 1'b0);
    stream_enable = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b0 || ram_we !== 1'b1 || ram_address !== 7'h41) begin
      failures++;
      $display("FAIL disable_comb: got ready=%b we=%b addr=%h expected 0 1 41", s_ready, ram_we, ram_address);
    end
    step();
    checks++;
    if (ram_we !== 1'b0 || half_request !== 1'b0) begin
      failures++;
      $display("FAIL disable_idle: got we=%b hreq=%b expected 0 0", ram_we, half_request);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_len00_prime();
    test_half_swap();
    test_underrun();
    test_simultaneous();
    test_sign();
    test_len128_disable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wts_wave_stream_writer.md
# wts_wave_stream_writer

Streams host samples into the wave RAM that the tone generator plays, so a channel can output waveforms longer than one table. Playback reads the buffer as two halves. The tone generator's `half_timing` pulse marks each half boundary. This block writes incoming samples into the half not being played, so the host can refill it while the other half sounds. It sits between the host-side sample interface and the wave RAM write port of one channel.

## Interface
Parameters:
- none (sizes fixed by wave-length register encoding)

Ports:
- `clk` in 1: system clock.
- `nreset` in 1: asynchronous, active-low reset.
- `stream_enable` in 1: 1 = streaming active; rising edge starts a stream.
- `reg_wave_length` in 2: buffer size. Latched on stream start. 00 = 32 entries, 01 = 64, 10/11 = 128.
- `half_timing` in 1: one-cycle pulse from the tone generator when playback finishes a half.
- `s_valid` in 1: host sample valid.
- `s_data` in 8: host sample.
- `s_ready` out 1: block accepts a sample this cycle.
- `ram_we` out 1: wave RAM write strobe, registered.
- `ram_address` out 7: wave RAM write address, registered.
- `ram_wdata` out 8: wave RAM write data, registered.
- `half_request` out 1: 1 while the target half is incomplete (state FILL).
- `fill_half` out 1: half currently being written.
- `underrun` out 1: sticky; playback crossed into a half before that half was complete.

## Operation
- Half size H = 16 (len 00), 32 (len 01), 64 (len 10/11).
- Half-select bit is bit 4, 5 or 6 of the address respectively.
- Write address = {zeros above the half bit, fill_half, index[log2(H)-1:0]}.
- Registers:
  - `state` ∈ {IDLE, FILL, WAIT}
  - `play_half`
  - `fill_half`
  - `index` (6 bits)
  - latched length (2 bits)
  - `underrun`
- IDLE:
  - `s_ready` = 0; `half_timing` is ignored.
  - On the rising edge of `stream_enable`: latch length, play_half = 0, fill_half = 1, index = 0, underrun = 0, go to FILL.
- FILL:
  - `s_ready` = 1. A beat is accepted when `s_valid && s_ready`.
  - Each accepted beat writes one RAM entry and increments `index`.
  - When the beat at index H-1 is accepted: go to WAIT, index = 0.
- WAIT:
  - `s_ready` = 0.
  - On `half_timing`: play_half toggles; fill_half = old play_half; index = 0; go to FILL.
- `half_timing` while in FILL (target half incomplete):
  - underrun is set.
  - The halves swap as in WAIT; index = 0; stay in FILL.
- Simultaneous events:
  - Accepted last beat (index H-1) and `half_timing` in the same cycle: the beat is written, there is no underrun, halves swap, next state is FILL.
  - Accepted non-last beat and `half_timing` in the same cycle: the beat is written to the old address, underrun is set, halves swap, index = 0.
- `stream_enable` low in any state: next state is IDLE and `s_ready` drops combinationally. A write for a beat accepted in the previous cycle is still issued. underrun holds its value until the next stream start.
- `reg_wave_length` changes while not in IDLE are ignored.
- `nreset` low at any time:
  - All outputs 0, state IDLE, all registers 0.
  - A pending write is discarded.

## Timing
- `s_ready` is combinational from state and `stream_enable` only. It never depends on `s_valid`.
- Accept in cycle N: `ram_we` = 1 with address and data in cycle N+1. `ram_we` is 1 for exactly one cycle per beat.
- Sustained throughput is one sample per clock in FILL.
- `half_timing` sampled in cycle N: new `fill_half` and `half_request` are visible in cycle N+1.
- Sample accepted in cycle N+1 targets the new half.
- `underrun` rises in the cycle after the offending `half_timing`.
- Stream start: `stream_enable` rising in cycle N gives `s_ready` = 1 in cycle N+1.

## Configuration
- `WTS_STREAM_SIGNED_EN`:
  - Defined: `s_data` is two's complement; `ram_wdata` = {~s_data[7], s_data[6:0]}, converted to the RAM's offset-binary format.
  - Undefined: `ram_wdata` = `s_data` unchanged.
  - All timing is identical in both builds.

## Test plan
- Reset mid-write: assert `nreset` low the cycle after an accept -> `ram_we` never rises; all outputs 0.
- Length 00 prime: start stream, 16 consecutive beats 0x00..0x0F -> writes to addresses 0x10..0x1F in consecutive cycles, then WAIT with `s_ready` = 0, `half_request` = 0.
- Half swap: in WAIT, pulse `half_timing` -> `fill_half` = 0; next 16 beats go to 0x00..0x0F; `underrun` stays 0.
- Underrun: length 01, accept 10 beats, then pulse `half_timing` -> `underrun` = 1; next beat goes to address 0x00.
- Simultaneous events: last beat and `half_timing` in the same cycle -> beat written to address H-1 of the old half; `underrun` = 0; next beat goes to index 0 of the other half.
- Sign conversion with `WTS_STREAM_SIGNED_EN` defined: `s_data` 0x80 -> `ram_wdata` 0x00, and 0x7F -> 0xFF. Without the macro, both values pass through unchanged.
